// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one block memory between the I-side and D-side caches.
// One transaction in flight; the winning request is captured at grant and replayed to memory.
//
// state | meaning
// IDLE  | no transaction in flight; grant a requesting client
// BUSY  | captured request driven to memory until mem_ready
module mem_arbiter #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic              i_write,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ready,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  localparam logic GNT_I = 1'b0;
  localparam logic GNT_D = 1'b1;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_last_grant;
  logic                r_owner;
  logic                r_op_wr;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;

  logic w_i_req;
  logic w_d_req;
  logic w_grant;
  logic w_grant_d;

  assign w_i_req   = i_read | i_write;
  assign w_d_req   = d_read | d_write;
  assign w_grant   = (r_state == S_IDLE) & (w_i_req | w_d_req);
  // On a tie the client that did not win last time goes first.
  assign w_grant_d = w_d_req & (~w_i_req | (r_last_grant == GNT_I));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_last_grant <= GNT_D;
      r_owner      <= GNT_I;
      r_op_wr      <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant) begin
        r_owner      <= w_grant_d;
        r_last_grant <= w_grant_d;
        // read+write together from a client is treated as a write
        r_op_wr      <= w_grant_d ? d_write : i_write;
        r_addr       <= w_grant_d ? d_addr  : i_addr;
        r_wdata      <= w_grant_d ? d_wdata : i_wdata;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_grant)   w_state_nxt = S_BUSY;
      S_BUSY:  if (mem_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    i_ready   = 1'b0;
    d_ready   = 1'b0;
    mem_addr  = r_addr;
    mem_wdata = r_wdata;
    if (r_state == S_BUSY) begin
      mem_read  = ~r_op_wr & ~mem_ready;
      mem_write =  r_op_wr & ~mem_ready;
      i_ready   = mem_ready & (r_owner == GNT_I);
      d_ready   = mem_ready & (r_owner == GNT_D);
    end
  end

  assign i_rdata = mem_rdata;
  assign d_rdata = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: latency, arbitration order, capture, reset abort.
module tb_mem_arbiter;

  localparam int ADDR_W = 28;
  localparam int DATA_W = 128;

  logic              clk_sys = 1'b0;
  logic              rst;
  logic              i_read, i_write, d_read, d_write;
  logic [ADDR_W-1:0] i_addr, d_addr;
  logic [DATA_W-1:0] i_wdata, d_wdata;
  logic [DATA_W-1:0] i_rdata, d_rdata;
  logic              i_ready, d_ready;
  logic              mem_read, mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [DATA_W-1:0] RDATA_A5 = {16{8'hA5}};
  localparam logic [DATA_W-1:0] WDATA_1  = 128'h0123_4567_89AB_CDEF_0;
  localparam logic [DATA_W-1:0] WDATA_2  = 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555;

  always #5 clk_sys = ~clk_sys;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk       (clk_sys),
    .rst       (rst),
    .i_read    (i_read),
    .i_write   (i_write),
    .i_addr    (i_addr),
    .i_wdata   (i_wdata),
    .i_rdata   (i_rdata),
    .i_ready   (i_ready),
    .d_read    (d_read),
    .d_write   (d_write),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .d_ready   (d_ready),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready)
  );

  task automatic check_eq(input string tag, input logic [DATA_W-1:0] got,
                          input logic [DATA_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // advance one clock; memory handshake pulse is one cycle wide
  task automatic tick();
    @(posedge clk_sys);
    #1;
    mem_ready = 1'b0;
  endtask

  // Called in an IDLE cycle with the expected winner requesting; runs it to its ready cycle.
  task automatic txn(input int lat, input bit exp_wr, input logic [ADDR_W-1:0] exp_addr,
                     input logic [DATA_W-1:0] exp_wdata, input bit exp_d, input string tag);
    for (int k = 1; k < lat; k++) begin
      tick();
      #1;
      check_eq({tag, "_rd"},    DATA_W'(mem_read),  DATA_W'(!exp_wr));
      check_eq({tag, "_wr"},    DATA_W'(mem_write), DATA_W'(exp_wr));
      check_eq({tag, "_addr"},  DATA_W'(mem_addr),  DATA_W'(exp_addr));
      check_eq({tag, "_wdata"}, mem_wdata,          exp_wdata);
      check_eq({tag, "_rdy_busy"}, DATA_W'({i_ready, d_ready}), '0);
    end
    tick();
    mem_ready = 1'b1;
    #1;
    check_eq({tag, "_strobe_drop"}, DATA_W'({mem_read, mem_write}), '0);
    check_eq({tag, "_i_ready"}, DATA_W'(i_ready), DATA_W'(!exp_d));
    check_eq({tag, "_d_ready"}, DATA_W'(d_ready), DATA_W'(exp_d));
    check_eq({tag, "_rdata"}, exp_d ? d_rdata : i_rdata, mem_rdata);
  endtask

  initial begin
    rst = 1'b1;
    {i_read, i_write, d_read, d_write} = '0;
    i_addr = '0; d_addr = '0; i_wdata = '0; d_wdata = '0;
    mem_rdata = RDATA_A5;
    mem_ready = 1'b0;

    tick();
    tick();
    #1;
    check_eq("rst_strobes", DATA_W'({mem_read, mem_write}), '0);
    check_eq("rst_ready",   DATA_W'({i_ready, d_ready}), '0);
    check_eq("rst_addr",    DATA_W'(mem_addr), '0);
    check_eq("rst_wdata",   mem_wdata, '0);

    // D read, latency 3
    rst = 1'b0;
    d_read = 1'b1; d_addr = 28'h0000010;
    txn(3, 1'b0, 28'h0000010, '0, 1'b1, "d_rd");
    d_read = 1'b0;
    tick();
    #1;
    check_eq("d_rd_idle", DATA_W'({mem_read, d_ready}), '0);

    // I write
    i_write = 1'b1; i_addr = 28'h1234567; i_wdata = WDATA_1;
    txn(2, 1'b1, 28'h1234567, WDATA_1, 1'b0, "i_wr");
    i_write = 1'b0;
    tick();

    // read+write together is a write
    d_read = 1'b1; d_write = 1'b1; d_addr = 28'h0000077; d_wdata = WDATA_2;
    txn(2, 1'b1, 28'h0000077, WDATA_2, 1'b1, "d_rw");
    d_read = 1'b0; d_write = 1'b0;
    tick();

    // stray mem_ready in IDLE
    mem_ready = 1'b1;
    #1;
    check_eq("idle_memrdy", DATA_W'({i_ready, d_ready, mem_read, mem_write}), '0);
    tick();

    // simultaneous requests right after reset: I first, then D
    rst = 1'b1;
    tick();
    rst = 1'b0;
    i_wdata = '0; d_wdata = '0;
    i_read = 1'b1; i_addr = 28'h0000111;
    d_read = 1'b1; d_addr = 28'h0000222;
    txn(2, 1'b0, 28'h0000111, '0, 1'b0, "tie_i");
    i_read = 1'b0;
    tick();
    txn(2, 1'b0, 28'h0000222, '0, 1'b1, "tie_d");

    // continuous requests from both: strict alternation starting with I
    i_read = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      #1;
      check_eq("rr_idle_gap", DATA_W'(mem_read), '0);
      txn(2, 1'b0, (k % 2 == 0) ? 28'h0000111 : 28'h0000222, '0, (k % 2) == 1, "rr");
    end
    i_read = 1'b0; d_read = 1'b0;
    tick();

    // address change while busy is ignored
    d_read = 1'b1; d_addr = 28'h0000005;
    tick();
    d_addr = 28'h0000009;
    #1;
    check_eq("hold_addr_1", DATA_W'(mem_addr), DATA_W'(28'h5));
    tick();
    #1;
    check_eq("hold_addr_2", DATA_W'(mem_addr), DATA_W'(28'h5));
    tick();
    mem_ready = 1'b1;
    #1;
    check_eq("hold_addr_rdy", DATA_W'(mem_addr), DATA_W'(28'h5));
    check_eq("hold_d_ready",  DATA_W'(d_ready),  DATA_W'(1'b1));
    d_read = 1'b0;
    tick();

    // reset two cycles into a pending read
    d_read = 1'b1; d_addr = 28'h0000033;
    tick();
    #1;
    check_eq("abort_rd_c1", DATA_W'(mem_read), DATA_W'(1'b1));
    tick();
    #1;
    check_eq("abort_rd_c2", DATA_W'(mem_read), DATA_W'(1'b1));
    rst = 1'b1;
    tick();
    #1;
    check_eq("abort_rd_low", DATA_W'(mem_read), '0);
    mem_ready = 1'b1;
    #1;
    check_eq("abort_no_rdy", DATA_W'({i_ready, d_ready}), '0);
    tick();
    rst = 1'b0;
    d_addr = 28'h0000044;
    txn(3, 1'b0, 28'h0000044, '0, 1'b1, "post_rst");
    d_read = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
